// File: rtl/i2c_target_regfile.sv
// I2C target exposing a pointer-addressed bank of 8-bit registers, fully synchronous to clk.
// SCL/SDA are synchronised and glitch-filtered; SDA drive changes a fixed hold time after SCL falls.
module i2c_target_regfile #(
  parameter logic [6:0] ADDRESS     = 7'h42,
  parameter int         NUM_REGS    = 4,
  parameter int         FILTER_LEN  = 3,
  parameter int         HOLD_CYCLES = 4,
  localparam int        PW          = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic [8*NUM_REGS-1:0] wr_regs,
  input  logic [8*NUM_REGS-1:0] rd_regs,
  output logic                  wr_strobe,
  output logic [PW-1:0]         wr_index,
  output logic                  rd_strobe,
  output logic                  busy
);

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_PTR       = 4'd3;
  localparam logic [3:0] ST_PTR_ACK   = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_WDATA_ACK = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_RDATA_ACK = 4'd8;

  localparam int            HW        = $clog2(HOLD_CYCLES + 1) + 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1'b1);
  localparam logic [2:0]    FLT_LAST  = 3'(FILTER_LEN - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(NUM_REGS - 1);

  // bit 0 carries SCL, bit 1 carries SDA through the whole input path
  logic [1:0]      meta_r, sync_r, filt_r, filt_d_r;
  logic [1:0][2:0] flt_cnt_r;
  logic            scl_rise_s, scl_fall_s, start_s, stop_s;
  logic [3:0]      state_r;
  logic [2:0]      bit_cnt_r;
  logic [7:0]      shift_r, byte_s;
  logic [PW-1:0]   ptr_r, ptr_next_s;
  logic            rw_r, drive_s;
  logic [HW-1:0]   hold_cnt_r;

  // Synchroniser plus hold filter: a level only moves after FILTER_LEN agreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_r    <= 2'b11;
      sync_r    <= 2'b11;
      filt_r    <= 2'b11;
      filt_d_r  <= 2'b11;
      flt_cnt_r <= '0;
    end else begin
      meta_r   <= {sda_in, scl_in};
      sync_r   <= meta_r;
      filt_d_r <= filt_r;
      for (int i = 0; i < 2; i++) begin
        if (sync_r[i] == filt_r[i]) begin
          flt_cnt_r[i] <= 3'd0;
        end else if (flt_cnt_r[i] == FLT_LAST) begin
          filt_r[i]    <= sync_r[i];
          flt_cnt_r[i] <= 3'd0;
        end else begin
          flt_cnt_r[i] <= flt_cnt_r[i] + 3'd1;
        end
      end
    end
  end

  assign scl_rise_s = filt_r[0] & ~filt_d_r[0];
  assign scl_fall_s = ~filt_r[0] & filt_d_r[0];
  assign start_s    = filt_r[0] & filt_d_r[1] & ~filt_r[1];
  assign stop_s     = filt_r[0] & ~filt_d_r[1] & filt_r[1];
  assign byte_s     = {shift_r[6:0], filt_r[1]};

  // Pointer advance with wrap at the top of the bank.
  always_comb begin
    ptr_next_s = ptr_r;
    if (ptr_r == PTR_LAST) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = ptr_r + PW'(1'b1);
    end
  end

  // SDA level wanted for the SCL-low phase that follows the current state's last rise.
  always_comb begin
    drive_s = 1'b0;
    case (state_r)
      ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: drive_s = 1'b1;
      ST_RDATA:                              drive_s = ~shift_r[7];
      default:                               drive_s = 1'b0;
    endcase
  end

  // Bus-condition handling, bit/byte FSM, register bank and delayed SDA drive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      ptr_r      <= '0;
      rw_r       <= 1'b0;
      hold_cnt_r <= '0;
      sda_oe     <= 1'b0;
      wr_regs    <= '0;
      wr_strobe  <= 1'b0;
      wr_index   <= '0;
      rd_strobe  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;
      if (start_s) begin
        state_r    <= ST_ADDR;
        bit_cnt_r  <= 3'd0;
        hold_cnt_r <= '0;
        sda_oe     <= 1'b0;
        busy       <= 1'b1;
      end else if (stop_s) begin
        state_r    <= ST_IDLE;
        bit_cnt_r  <= 3'd0;
        hold_cnt_r <= '0;
        sda_oe     <= 1'b0;
        busy       <= 1'b0;
      end else begin
        if (scl_fall_s) begin
          hold_cnt_r <= HOLD_INIT;
        end else if (hold_cnt_r != '0) begin
          hold_cnt_r <= hold_cnt_r - HOLD_ONE;
          if (hold_cnt_r == HOLD_ONE) begin
            sda_oe <= drive_s;
          end
        end
        if (scl_rise_s) begin
          case (state_r)
            ST_ADDR, ST_PTR, ST_WDATA: begin
              shift_r   <= byte_s;
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                if (state_r == ST_ADDR) begin
                  if (byte_s[7:1] == ADDRESS) begin
                    rw_r    <= byte_s[0];
                    state_r <= ST_ADDR_ACK;
                  end else begin
                    state_r <= ST_IDLE;
                  end
                end else if (state_r == ST_PTR) begin
                  if (byte_s < 8'(NUM_REGS)) begin
                    ptr_r   <= byte_s[PW-1:0];
                    state_r <= ST_PTR_ACK;
                  end else begin
                    state_r <= ST_IDLE;
                  end
                end else begin
                  state_r <= ST_WDATA_ACK;
                end
              end
            end
            ST_ADDR_ACK: begin
              if (rw_r) begin
                shift_r   <= rd_regs[{ptr_r, 3'b000} +: 8];
                rd_strobe <= 1'b1;
                state_r   <= ST_RDATA;
              end else begin
                state_r <= ST_PTR;
              end
            end
            ST_PTR_ACK: state_r <= ST_WDATA;
            ST_WDATA_ACK: begin
              wr_regs[{ptr_r, 3'b000} +: 8] <= shift_r;
              wr_strobe <= 1'b1;
              wr_index  <= ptr_r;
              ptr_r     <= ptr_next_s;
              state_r   <= ST_WDATA;
            end
            ST_RDATA: begin
              shift_r   <= {shift_r[6:0], 1'b0};
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                state_r <= ST_RDATA_ACK;
              end
            end
            ST_RDATA_ACK: begin
              ptr_r <= ptr_next_s;
              // controller ACK (SDA low) asks for the next byte
              if (!filt_r[1]) begin
                shift_r   <= rd_regs[{ptr_next_s, 3'b000} +: 8];
                rd_strobe <= 1'b1;
                state_r   <= ST_RDATA;
              end else begin
                state_r <= ST_IDLE;
              end
            end
            default: state_r <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/i2c_target_regfile.md
Name: i2c_target_regfile

Overview:
- Second-generation I2C target: fully synchronous to the system clock. SCL and SDA are oversampled, synchronised and glitch-filtered instead of being used as clocks.
- Exposes a parametrised bank of 8-bit registers. The first write byte sets a register pointer. Later bytes write or read at the pointer, which auto-increments.
- Supports repeated START, NACK on bad address or pointer, and read-back of host-supplied status values.
- Sits between the board I2C pads (open-drain, external pull-ups) and the FPGA core logic.

Parameters:
- ADDRESS, 7'h42, 7-bit target address.
- NUM_REGS, 4, number of 8-bit registers (2..16). Pointer width PW = $clog2(NUM_REGS).
- FILTER_LEN, 3, consecutive equal synchronised samples required before a filtered SCL/SDA level changes (1..7).
- HOLD_CYCLES, 4, clk cycles after a filtered SCL fall before sda_oe may change.

Ports:
- clk  in  1  system clock, ≥ 20× SCL frequency
- reset  in  1  asynchronous, active-high
- scl_in  in  1  SCL pad input
- sda_in  in  1  SDA pad input
- sda_oe  out  1  1 = pull SDA low (pad driven 0), 0 = release (pad high-Z)
- wr_regs  out  8*NUM_REGS  write bank; byte i is at [8i+7:8i]
- rd_regs  in  8*NUM_REGS  read bank supplied by the core
- wr_strobe  out  1  one-cycle pulse after a data byte is written to wr_regs
- wr_index  out  PW  register index written; valid with wr_strobe
- rd_strobe  out  1  one-cycle pulse when a read byte is loaded for transmission
- busy  out  1  high from START until STOP

Behaviour:
- Reset values: wr_regs=0, pointer=0, sda_oe=0, wr_strobe=0, rd_strobe=0, busy=0, state=IDLE. Asserting reset mid-transfer releases SDA within the same cycle.
- Input path:
  - 2-flop synchroniser, then FILTER_LEN majority-hold filter, giving scl_f and sda_f.
  - Edge detectors produce one-cycle pulses scl_rise and scl_fall.
- Bus conditions:
  - START: sda_f falls while scl_f = 1. Clears bit counter and goes to ADDR from any state, which covers repeated START. busy becomes 1.
  - STOP: sda_f rises while scl_f = 1. Goes to IDLE, releases SDA, busy becomes 0. The pointer is retained.
- Data sampling and driving:
  - Data is sampled on scl_rise, MSB first (I2C order).
  - sda_oe changes only HOLD_CYCLES cycles after scl_fall.
  - A bit counter (0..7) advances on scl_rise. After the 8th bit the FSM enters the matching ACK state.
- States:
  - IDLE: ignore everything except START.
  - ADDR: shift 8 bits.
    - If addr[7:1] ≠ ADDRESS, go to IDLE with no ACK.
    - Else go to ADDR_ACK and drive ACK (sda_oe = 1) for the 9th clock.
    - Next state is PTR when R/W = 0, or RDATA when R/W = 1.
  - PTR: receive the pointer byte.
    - If value < NUM_REGS: ACK, load pointer, go to WDATA.
    - Else: NACK (sda_oe stays 0), pointer unchanged, go to IDLE.
  - WDATA: receive a byte and ACK it.
    - On the ACK scl_rise: write wr_regs[pointer], pulse wr_strobe with wr_index = pointer.
    - Then pointer = (pointer + 1) mod NUM_REGS, so NUM_REGS−1 wraps to 0. Return to WDATA.
  - RDATA:
    - On entry, latch rd_regs[pointer] into the shift register and pulse rd_strobe.
    - Drive each bit after scl_fall + HOLD_CYCLES. A bit of 1 releases SDA; a bit of 0 pulls it low.
  - RDATA_ACK:
    - Release SDA and sample the controller response on scl_rise.
    - ACK (0): pointer increments with wrap, back to RDATA.
    - NACK (1): go to IDLE, pointer incremented.
- Boundary rules:
  - START or STOP in the middle of a byte aborts it. No partial write; no wr_strobe.
  - A STOP during a NACK'd transfer is harmless.
  - A scl_rise and a START on the same cycle: START wins.
  - The ACK drive begins after the scl_fall that ends bit 8 and releases after the scl_fall that ends bit 9.

Test Plan:
- Write 0x84 (addr 0x42+W), ptr 0x01, data 0xA5, 0x3C, STOP -> target ACKs all 4 bytes. wr_regs[1]=0xA5, wr_regs[2]=0x3C. Two wr_strobe pulses with index 1 then 2. busy drops after STOP.
- NUM_REGS=4: ptr 0x03, then data 0x11, 0x22 -> wr_regs[3]=0x11, wr_regs[0]=0x22 (wrap).
- Write ptr 0x02, repeated START, 0x85 (addr+R), rd_regs = {0xDD,0xCC,0xBB,0xAA}, controller ACKs 1 byte then NACKs -> SDA bytes 0xCC then 0xDD. Two rd_strobe pulses. Then IDLE.
- Address 0x50+W -> sda_oe never asserts and wr_regs is unchanged. A following valid transfer is still accepted.
- Pointer byte 0x07 with NUM_REGS=4 -> NACK on the 9th clock. Subsequent data is ignored and the pointer stays at its previous value.
- STOP after 4 bits of a data byte -> no wr_strobe, no wr_regs change. Also: 1-clk glitches on SCL shorter than FILTER_LEN produce no bit. Also: reset asserted while ACK is driven -> sda_oe=0 immediately.
